// File: rtl/adder_6bits.sv
// Registered 6-bit unsigned adder built from a ripple chain of full-adder cells.
// The 7-bit result, with the true carry-out in bit 6, is registered every cycle.

module adder_6bits_ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module adder_6bits_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  adder_6bits_ha u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  adder_6bits_ha u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));

  assign o_c = w_c0 | w_c1;
endmodule

module adder_6bits (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic [5:0] i_w_a,
  input  logic [5:0] i_w_b,
  output logic [6:0] o_w_s
);
  // w_carry[k] is the carry into stage k; stage 0 has no carry-in.
  logic [6:0] w_carry;
  logic [5:0] w_sum;
  logic [6:0] r_s;

  assign w_carry[0] = 1'b0;

  for (genvar k = 0; k < 6; k++) begin : g_stage
    adder_6bits_fa u_fa (
      .i_a(i_w_a[k]),
      .i_b(i_w_b[k]),
      .i_c(w_carry[k]),
      .o_s(w_sum[k]),
      .o_c(w_carry[k+1])
    );
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) r_s <= 7'd0;
    else           r_s <= {w_carry[6], w_sum};
  end

  assign o_w_s = r_s;
endmodule

// File: tb/tb_adder_6bits.sv
// Directed vector bench for adder_6bits: reset, corner sums, back-to-back,
// full operand sweep with a mid-stream reset, and a between-edge input glitch.

module tb_adder_6bits;
  logic       clk;
  logic       rst;
  logic [5:0] a;
  logic [5:0] b;
  logic [6:0] s;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [5:0] a;
    logic [5:0] b;
    logic [6:0] exp;
  } vec_t;

  adder_6bits dut (
    .i_w_clk  (clk),
    .i_w_reset(rst),
    .i_w_a    (a),
    .i_w_b    (b),
    .o_w_s    (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] exp);
    checks++;
    if (s !== exp) begin
      failures++;
      $display("FAIL %s: o_w_s=%0d expected=%0d", name, s, exp);
    end
  endtask

  // Drive one operand pair, let the edge capture it, then check just after.
  task automatic step(input logic r, input logic [5:0] va, input logic [5:0] vb,
                      input logic [6:0] exp, input string name);
    rst = r;
    a   = va;
    b   = vb;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 6'd63, 6'd63, 7'd0};
    vecs[1]  = '{1'b1, 6'd63, 6'd63, 7'd0};
    vecs[2]  = '{1'b0, 6'd63, 6'd63, 7'd126};
    vecs[3]  = '{1'b0, 6'd0,  6'd0,  7'd0};
    vecs[4]  = '{1'b0, 6'd63, 6'd0,  7'd63};
    vecs[5]  = '{1'b0, 6'd0,  6'd63, 7'd63};
    vecs[6]  = '{1'b0, 6'd63, 6'd1,  7'd64};
    vecs[7]  = '{1'b0, 6'd32, 6'd32, 7'd64};
    vecs[8]  = '{1'b0, 6'd63, 6'd63, 7'd126};
    vecs[9]  = '{1'b0, 6'd1,  6'd2,  7'd3};
    vecs[10] = '{1'b0, 6'd62, 6'd1,  7'd63};
    vecs[11] = '{1'b0, 6'd21, 6'd42, 7'd63};
    vecs[12] = '{1'b1, 6'd21, 6'd42, 7'd0};

    rst = 1'b1;
    a   = 6'd0;
    b   = 6'd0;
    #2;

    for (int i = 0; i < 13; i++)
      step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Sweep every pair; one cycle of reset lands on A=40, B=30.
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        if (ia == 40 && ib == 30) begin
          step(1'b1, 6'(ia), 6'(ib), 7'd0, "sweep_reset");
        end else begin
          step(1'b0, 6'(ia), 6'(ib), 7'(ia + ib),
               $sformatf("sweep_%0d_%0d", ia, ib));
        end
      end
    end

    // Glitch on A between edges must not reach the register.
    step(1'b0, 6'd20, 6'd10, 7'd30, "glitch_prior");
    a = 6'd5;
    b = 6'd10;
    #2;
    check("glitch_hold_a5", 7'd30);
    a = 6'd60;
    #2;
    check("glitch_hold_a60", 7'd30);
    a = 6'd5;
    @(posedge clk);
    #1;
    check("glitch_after", 7'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
